// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: write-only HD44780-style LCD bus sequencer.
// Each accepted write is sent as one strobe (byte mode, BUS_W=8) or as two
// strobes, high nibble first (nibble mode, BUS_W=4). The strobe is framed by
// setup/hold intervals and followed by an execution wait. The wait is long
// (T_LONG) for clear/home commands (rs=0, data 0x01..0x03) and T_WAIT otherwise.
//
// Ports:
//   clk       clock
//   reset     synchronous, active-high reset
//   in_valid  write request
//   in_ready  block can accept a write (IDLE only)
//   in_rs     register select of the write (0 command, 1 data)
//   in_data   byte to write
//   lcd_rs    LCD register select, held until the next accept
//   lcd_rw    LCD read/write, tied to 0 (write only)
//   lcd_e     LCD enable strobe
//   lcd_d     LCD data bus (byte or nibble)
//   busy      complement of in_ready
module lcd_bus_writer #(
  parameter int BUS_W   = 8,
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 12,
  parameter int T_HOLD  = 2,
  parameter int T_WAIT  = 2000,
  parameter int T_LONG  = 80000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_rs,
  input  logic [7:0]       in_data,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic             lcd_e,
  output logic [BUS_W-1:0] lcd_d,
  output logic             busy
);

  // 20 bits covers every legal wait length (up to 2^20-1 cycles).
  localparam int CNT_W = 20;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Counters are loaded with length-1 and count down to zero.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(T_WAIT - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(T_LONG - 1);
  localparam logic NIBBLE = 1'(BUS_W == 4);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    WAIT  = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             phase_r, phase_s;   // 1 while sending the low nibble
  logic             rs_r, rs_s;
  logic [7:0]       data_r, data_s;
  logic [3:0]       nib_s;
  logic [7:0]       bus_s;

  // Clear-display and return-home commands need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    is_long_cmd = (rs == 1'b0) && (d >= 8'd1) && (d <= 8'd3);
  endfunction

  // Next-state, counter and capture logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    phase_s = phase_r;
    rs_s    = rs_r;
    data_s  = data_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_s = SETUP;
          cnt_s   = SETUP_LD;
          phase_s = 1'b0;
          rs_s    = in_rs;
          data_s  = in_data;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = PULSE;
          cnt_s   = PULSE_LD;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      PULSE: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = HOLD;
          cnt_s   = HOLD_LD;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt_r == CNT_ZERO) begin
          if (NIBBLE && !phase_r) begin
            // Second half of a nibble transfer: low nibble goes out next.
            state_s = SETUP;
            cnt_s   = SETUP_LD;
            phase_s = 1'b1;
          end else begin
            state_s = WAIT;
            cnt_s   = is_long_cmd(rs_r, data_r) ? LONG_LD : WAIT_LD;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Bus value derived from the next-cycle capture so it is registered in step
  // with the state; it stays put while data/phase are unchanged (WAIT, IDLE).
  always_comb begin
    nib_s = phase_s ? data_s[3:0] : data_s[7:4];
    if (NIBBLE) begin
      bus_s = {4'h0, nib_s};
    end else begin
      bus_s = data_s;
    end
  end

  // State, capture and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
      phase_r  <= 1'b0;
      rs_r     <= 1'b0;
      data_r   <= 8'h00;
      in_ready <= 1'b0;
      busy     <= 1'b1;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_d    <= {BUS_W{1'b0}};
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      phase_r  <= phase_s;
      rs_r     <= rs_s;
      data_r   <= data_s;
      in_ready <= (state_s == IDLE);
      busy     <= (state_s != IDLE);
      lcd_e    <= (state_s == PULSE);
      lcd_rs   <= rs_s;
      lcd_d    <= bus_s[BUS_W-1:0];
    end
  end

  // Write-only interface.
  assign lcd_rw = 1'b0;

endmodule

// File: doc/lcd_bus_writer.md
LCD_BUS_WRITER -- requirements
Module: lcd_bus_writer

Interface
REQ-001 SHALL have parameter BUS_W, default 8, LCD data bus width; legal values 8 (byte mode) or 4 (nibble mode).
REQ-002 SHALL have parameter T_SETUP, default 2, cycles RS/data are stable before E rises; range 1..255.
REQ-003 SHALL have parameter T_PULSE, default 12, cycles E is high; range 1..255.
REQ-004 SHALL have parameter T_HOLD, default 2, cycles RS/data are held after E falls; range 1..255.
REQ-005 SHALL have parameter T_WAIT, default 2000, post-transfer execution wait in cycles for ordinary writes; range 1..2^20-1.
REQ-006 SHALL have parameter T_LONG, default 80000, execution wait in cycles for clear/home commands; range 1..2^20-1.
REQ-007 SHALL have port clk, input, 1, clock.
REQ-008 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-009 SHALL have port in_valid, input, 1, write request.
REQ-010 SHALL have port in_ready, output, 1, block can accept a write.
REQ-011 SHALL have port in_rs, input, 1, register select: 0 = command, 1 = data.
REQ-012 SHALL have port in_data, input, 8, byte to write.
REQ-013 SHALL have port lcd_rs, output, 1, LCD register select.
REQ-014 SHALL have port lcd_rw, output, 1, LCD read/write; constant 0.
REQ-015 SHALL have port lcd_e, output, 1, LCD enable strobe.
REQ-016 SHALL have port lcd_d, output, BUS_W, LCD data bus.
REQ-017 SHALL have port busy, output, 1, equal to NOT in_ready.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, PULSE, HOLD, WAIT; all outputs SHALL be registered.
REQ-019 in_ready SHALL be 1 only in IDLE; a write is accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-020 On accept (call it cycle 0): SHALL capture in_rs and in_data, and SHALL enter SETUP at cycle 1.
REQ-021 lcd_rs and lcd_d SHALL be driven from cycle 1 and SHALL hold their values through WAIT and IDLE until the next accept.
REQ-022 SETUP SHALL last exactly T_SETUP cycles, then go to PULSE.
REQ-023 PULSE SHALL last exactly T_PULSE cycles, with lcd_e=1 during PULSE only, then go to HOLD.
REQ-024 HOLD SHALL last exactly T_HOLD cycles, with lcd_e=0.
REQ-025 Byte mode: HOLD SHALL go to WAIT, with lcd_d = captured byte.
REQ-026 Nibble mode, first phase: lcd_d SHALL carry data[7:4].
REQ-027 Nibble mode, end of first HOLD: SHALL switch lcd_d to data[3:0] and return to SETUP for a second SETUP/PULSE/HOLD sequence, then go to WAIT.
REQ-028 WAIT SHALL last T_LONG cycles if the captured rs=0 and data is 0x01, 0x02 or 0x03; otherwise it SHALL last T_WAIT cycles.
REQ-029 After WAIT, SHALL return to IDLE.
REQ-030 Latency: in_ready SHALL return to 1 at cycle 1 + N*(T_SETUP+T_PULSE+T_HOLD) + Twait, where N=1 in byte mode and N=2 in nibble mode.
REQ-031 in_valid while not ready: SHALL be ignored with no capture; in_data changes mid-transfer SHALL NOT affect outputs.
REQ-032 Back-to-back: a new write SHALL be acceptable in the first IDLE cycle; no extra idle cycle is required.
REQ-033 Counters SHALL be wide enough for the maximum parameter values and SHALL NOT wrap within any state.
REQ-034 lcd_rw SHALL be 0 at all times, including during reset.

Reset
REQ-035 While reset=1 at a clock edge: state SHALL be IDLE, and lcd_e=0, lcd_rs=0, lcd_d=0, counters=0.
REQ-036 While reset=1 at a clock edge: in_ready SHALL be 0 and busy SHALL be 1.
REQ-037 First edge with reset=0: in_ready SHALL be 1.
REQ-038 Reset asserted mid-transfer (any state): SHALL abort the transfer, drive lcd_e=0 from the next edge, and discard the captured byte; no further strobe SHALL occur.
REQ-039 in_valid during reset SHALL be ignored.

Verification
REQ-040 SHALL cover, with byte mode, T=2/3/2, T_WAIT=10: write rs=1, 0x41 -> lcd_rs=1, lcd_d=0x41 from cycle 1, lcd_e high in cycles 3-5, in_ready=1 at cycle 18.
REQ-041 SHALL cover, with nibble mode and the same timing: write rs=1, 0xA5 -> lcd_d=0xA during the first strobe, lcd_d=0x5 during the second, exactly two E pulses, in_ready at cycle 25.
REQ-042 SHALL cover, with byte mode and T_LONG=50: write rs=0, 0x01 -> in_ready at cycle 58; the same for rs=1, 0x01 -> cycle 18 (no long wait).
REQ-043 SHALL cover in_valid held high continuously with changing in_data -> each byte accepted only in IDLE, strobes are gap-free back-to-back, and no byte is duplicated or corrupted.
REQ-044 SHALL cover reset asserted during PULSE -> lcd_e=0 at the next edge, outputs zero, and in_ready=1 on the first edge after release; the next write behaves normally.
REQ-045 SHALL cover T_SETUP=T_PULSE=T_HOLD=T_WAIT=1 -> E high exactly 1 cycle, and in_ready returns at cycle 5 in byte mode.
